// File: rtl/psimd_pkg.sv
// psimd_pkg: shared encodings, packet type and FSM states for the PSIMD issue stage
package psimd_pkg;
  localparam int NREG = 32;
  localparam int RW   = 5;

  localparam logic [3:0] ENA_NOP    = 4'd0;
  localparam logic [3:0] ENA_ADDSUB = 4'd1;
  localparam logic [3:0] ENA_MUL    = 4'd2;
  localparam logic [3:0] ENA_DIV    = 4'd3;
  localparam logic [3:0] ENA_SQRT   = 4'd4;
  localparam logic [3:0] ENA_SGNJ   = 4'd5;
  localparam logic [3:0] ENA_CMP    = 4'd6;
  localparam logic [3:0] ENA_ITF    = 4'd7;
  localparam logic [3:0] ENA_FTI    = 4'd8;
  localparam logic [3:0] ENA_FMA    = 4'd9;

  typedef struct packed {
    logic [3:0]    ena;
    logic [2:0]    rm;
    logic [2:0]    sel2;
    logic [1:0]    sel1;
    logic          op;
    logic          sp;
    logic          fti_ctrl;
    logic          wr_enable;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rs3;
    logic [RW-1:0] rd;
  } issue_pkt_t;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  function automatic logic is_divsqrt(input logic [3:0] ena);
    return ena == ENA_DIV || ena == ENA_SQRT;
  endfunction
endpackage

// File: rtl/psimd_scoreboard.sv
// psimd_scoreboard: pending-write bits with same-cycle writeback forwarded as free
module psimd_scoreboard
  import psimd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_set,
  input  logic [RW-1:0] i_set_idx,
  input  logic          i_clr,
  input  logic [RW-1:0] i_clr_idx,
  input  logic [RW-1:0] i_rs1,
  input  logic [RW-1:0] i_rs2,
  input  logic [RW-1:0] i_rs3,
  input  logic [RW-1:0] i_rd,
  output logic          o_hit_rs1,
  output logic          o_hit_rs2,
  output logic          o_hit_rs3,
  output logic          o_hit_rd
);
  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_eff;
  logic [NREG-1:0] w_set;

  assign w_eff     = r_sb & ~(NREG'(i_clr) << i_clr_idx);
  assign w_set     = NREG'(i_set) << i_set_idx;
  assign o_hit_rs1 = w_eff[i_rs1];
  assign o_hit_rs2 = w_eff[i_rs2];
  assign o_hit_rs3 = w_eff[i_rs3];
  assign o_hit_rd  = w_eff[i_rd];

  // clear on writeback, set on accept; set wins on the same index
  always_ff @(posedge clk)
    if (rst || i_flush) r_sb <= '0;
    else r_sb <= w_eff | w_set;
endmodule

// File: rtl/psimd_issue_stage.sv
// psimd_issue_stage: single-entry issue register with scoreboard and div/sqrt interlock
module psimd_issue_stage
  import psimd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic [3:0]    dec_ena,
  input  logic [2:0]    dec_rm,
  input  logic [2:0]    dec_sel2,
  input  logic [1:0]    dec_sel1,
  input  logic          dec_op,
  input  logic          dec_sp,
  input  logic          dec_fti_ctrl,
  input  logic          dec_wr_enable,
  input  logic [RW-1:0] dec_rs1,
  input  logic [RW-1:0] dec_rs2,
  input  logic [RW-1:0] dec_rs3,
  input  logic [RW-1:0] dec_rd,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [3:0]    iss_ena,
  output logic [2:0]    iss_rm,
  output logic [2:0]    iss_sel2,
  output logic [1:0]    iss_sel1,
  output logic          iss_op,
  output logic          iss_sp,
  output logic          iss_fti_ctrl,
  output logic          iss_wr_enable,
  output logic [RW-1:0] iss_rs1,
  output logic [RW-1:0] iss_rs2,
  output logic [RW-1:0] iss_rs3,
  output logic [RW-1:0] iss_rd,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_rd,
  input  logic          divsqrt_done
);
  issue_pkt_t r_pkt, w_dec;
  state_t     r_state, w_state_nxt;
  logic       r_busy;
  logic       w_hit1, w_hit2, w_hit3, w_hitd;
  logic       w_use2, w_hazard, w_fire, w_load;

  assign w_dec = {dec_ena, dec_rm, dec_sel2, dec_sel1, dec_op, dec_sp, dec_fti_ctrl,
                  dec_wr_enable, dec_rs1, dec_rs2, dec_rs3, dec_rd};
  assign {iss_ena, iss_rm, iss_sel2, iss_sel1, iss_op, iss_sp, iss_fti_ctrl,
          iss_wr_enable, iss_rs1, iss_rs2, iss_rs3, iss_rd} = r_pkt;

  assign w_use2    = !(dec_ena == ENA_SQRT || dec_ena == ENA_ITF || dec_ena == ENA_FTI);
  assign w_hazard  = (dec_ena != ENA_NOP && w_hit1) || (w_use2 && w_hit2) ||
                     (dec_ena == ENA_FMA && w_hit3) || (dec_wr_enable && w_hitd);
  assign iss_valid = r_state == ST_FULL && !(is_divsqrt(r_pkt.ena) && r_busy && !divsqrt_done);
  assign w_fire    = iss_valid && iss_ready;
  assign dec_ready = !rst && !flush && (r_state == ST_EMPTY || w_fire) && !w_hazard;
  assign w_load    = dec_valid && dec_ready && dec_ena != ENA_NOP;

  psimd_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_set     (w_load && dec_wr_enable),
    .i_set_idx (dec_rd),
    .i_clr     (wb_valid),
    .i_clr_idx (wb_rd),
    .i_rs1     (dec_rs1),
    .i_rs2     (dec_rs2),
    .i_rs3     (dec_rs3),
    .i_rd      (dec_rd),
    .o_hit_rs1 (w_hit1),
    .o_hit_rs2 (w_hit2),
    .o_hit_rs3 (w_hit3),
    .o_hit_rd  (w_hitd)
  );

  // a real instruction fills the register; issue without refill empties it
  always_comb
    w_state_nxt = w_load ? ST_FULL : w_fire ? ST_EMPTY : r_state;

  // pipeline register occupancy
  always_ff @(posedge clk)
    if (rst || flush) r_state <= ST_EMPTY;
    else r_state <= w_state_nxt;

  // packet holds steady until the next real instruction is accepted
  always_ff @(posedge clk)
    if (rst) r_pkt <= '0;
    else if (w_load) r_pkt <= w_dec;

  // shared div/sqrt unit occupancy; a new launch wins over a completion
  always_ff @(posedge clk)
    if (rst || flush) r_busy <= 1'b0;
    else if (w_fire && is_divsqrt(r_pkt.ena)) r_busy <= 1'b1;
    else if (divsqrt_done) r_busy <= 1'b0;
endmodule

// File: tb/tb_psimd_issue_stage.sv
// tb_psimd_issue_stage: directed scenarios plus randomized traffic against a reference model
module tb_psimd_issue_stage;
  logic       clk = 0;
  logic       rst, flush, dec_valid, dec_ready;
  logic [3:0] dec_ena;
  logic [2:0] dec_rm, dec_sel2;
  logic [1:0] dec_sel1;
  logic       dec_op, dec_sp, dec_fti_ctrl, dec_wr_enable;
  logic [4:0] dec_rs1, dec_rs2, dec_rs3, dec_rd;
  logic       iss_valid, iss_ready;
  logic [3:0] iss_ena;
  logic [2:0] iss_rm, iss_sel2;
  logic [1:0] iss_sel1;
  logic       iss_op, iss_sp, iss_fti_ctrl, iss_wr_enable;
  logic [4:0] iss_rs1, iss_rs2, iss_rs3, iss_rd;
  logic       wb_valid, divsqrt_done;
  logic [4:0] wb_rd;

  int n_checks = 0;
  int n_errs   = 0;

  bit [31:0] m_pend;
  bit        m_busy, m_full;
  bit [35:0] m_pkt;

  always #5 clk = ~clk;

  psimd_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_ena(dec_ena), .dec_rm(dec_rm),
    .dec_sel2(dec_sel2), .dec_sel1(dec_sel1), .dec_op(dec_op), .dec_sp(dec_sp),
    .dec_fti_ctrl(dec_fti_ctrl), .dec_wr_enable(dec_wr_enable),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3), .dec_rd(dec_rd),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ena(iss_ena), .iss_rm(iss_rm),
    .iss_sel2(iss_sel2), .iss_sel1(iss_sel1), .iss_op(iss_op), .iss_sp(iss_sp),
    .iss_fti_ctrl(iss_fti_ctrl), .iss_wr_enable(iss_wr_enable),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rs3(iss_rs3), .iss_rd(iss_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .divsqrt_done(divsqrt_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit pending(input bit [4:0] r);
    return m_pend[r] && !(wb_valid && wb_rd == r);
  endfunction

  // compare against the model at mid-cycle, then advance the model across the edge
  task automatic tick();
    bit haz, ev, fire, er, acc, ds;
    #1;
    haz = (dec_ena != 0 && pending(dec_rs1)) ||
          (!(dec_ena inside {4'd4, 4'd7, 4'd8}) && pending(dec_rs2)) ||
          (dec_ena == 9 && pending(dec_rs3)) || (dec_wr_enable && pending(dec_rd));
    ds   = m_pkt[35:32] inside {4'd3, 4'd4};
    ev   = m_full && !(ds && m_busy && !divsqrt_done);
    fire = ev && iss_ready;
    er   = !rst && !flush && (!m_full || fire) && !haz;
    acc  = dec_valid && er;
    check("iss_valid", iss_valid, ev);
    check("dec_ready", dec_ready, er);
    check("iss_pkt", {iss_ena, iss_rm, iss_sel2, iss_sel1, iss_op, iss_sp, iss_fti_ctrl,
                      iss_wr_enable, iss_rs1, iss_rs2, iss_rs3, iss_rd}, m_pkt);
    if (rst || flush) begin
      m_pend = 0;
      m_busy = 0;
      m_full = 0;
      if (rst) m_pkt = 0;
    end else begin
      if (wb_valid) m_pend[wb_rd] = 0;
      if (acc && dec_ena != 0 && dec_wr_enable) m_pend[dec_rd] = 1;
      if (fire && ds) m_busy = 1;
      else if (divsqrt_done) m_busy = 0;
      if (acc && dec_ena != 0) begin
        m_full = 1;
        m_pkt = {dec_ena, dec_rm, dec_sel2, dec_sel1, dec_op, dec_sp, dec_fti_ctrl,
                 dec_wr_enable, dec_rs1, dec_rs2, dec_rs3, dec_rd};
      end else if (fire) m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic dec(input bit [3:0] e, input bit [4:0] a, b, c, d, input bit w);
    dec_valid = 1;
    dec_ena = e;
    dec_rs1 = a;
    dec_rs2 = b;
    dec_rs3 = c;
    dec_rd = d;
    dec_wr_enable = w;
    {dec_rm, dec_sel2, dec_sel1, dec_op, dec_sp, dec_fti_ctrl} = 12'($urandom);
  endtask

  // build sb={1,4}, busy and a held packet, then kill with flush or reset
  task automatic kill(input bit use_rst);
    flush = 1; tick(); flush = 0;
    iss_ready = 1;
    dec(1, 2, 3, 0, 1, 1); tick();
    dec(3, 5, 6, 0, 4, 1); tick();
    dec_valid = 0; tick();
    iss_ready = 0;
    dec(2, 7, 8, 0, 0, 0); tick();
    dec_valid = 0;
    if (use_rst) rst = 1; else flush = 1;
    tick();
    rst = 0; flush = 0;
    #1 check(use_rst ? "rst_valid" : "flush_valid", iss_valid, 0);
    wb_valid = 1; wb_rd = 1; tick();
    wb_valid = 0;
    dec(1, 1, 4, 0, 4, 1);
    #1 check(use_rst ? "rst_sb" : "flush_sb", dec_ready, 1);
    tick();
    dec_valid = 0; iss_ready = 1; tick();
  endtask

  initial begin
    rst = 1; flush = 0; iss_ready = 0; wb_valid = 0; wb_rd = 0; divsqrt_done = 0;
    dec(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 check("rst_ready", dec_ready, 0);
    tick(); tick();
    rst = 0; dec_valid = 0; iss_ready = 1; tick();
    // back-to-back independent ops
    dec(1, 2, 3, 0, 1, 1); tick();
    dec(2, 5, 6, 0, 4, 1);
    #1 check("b2b_ready", dec_ready, 1);
    check("b2b_first_valid", iss_valid, 1);
    tick();
    dec_valid = 0; tick();
    // RAW on r4 resolved by forwarded writeback
    dec(1, 4, 2, 0, 7, 1);
    #1 check("raw_stall", dec_ready, 0);
    tick(); tick();
    wb_valid = 1; wb_rd = 4;
    #1 check("raw_fwd", dec_ready, 1);
    tick();
    wb_valid = 0; dec_valid = 0; tick(); tick();
    wb_valid = 1; wb_rd = 1; tick();
    wb_rd = 7; tick();
    wb_valid = 0;
    // div/sqrt interlock
    dec(3, 11, 12, 0, 8, 1); tick();
    dec_valid = 0; tick();
    dec(4, 10, 0, 0, 9, 1); tick();
    dec_valid = 0;
    #1 check("busy_hold", iss_valid, 0);
    tick(); tick();
    divsqrt_done = 1;
    #1 check("done_issue", iss_valid, 1);
    tick();
    divsqrt_done = 0;
    dec(3, 14, 15, 0, 13, 1); tick();
    dec_valid = 0;
    #1 check("busy_kept", iss_valid, 0);
    tick();
    divsqrt_done = 1; tick(); divsqrt_done = 0; tick();
    divsqrt_done = 1; tick(); divsqrt_done = 0;
    flush = 1; tick(); flush = 0;
    // unused rs2 ignored, rs3 used by fma
    dec(2, 5, 6, 0, 4, 1); tick();
    dec_valid = 0; tick();
    dec(8, 1, 4, 0, 20, 1);
    #1 check("fti_rs2", dec_ready, 1);
    tick();
    dec(9, 1, 2, 4, 21, 1);
    #1 check("fma_rs3", dec_ready, 0);
    tick();
    // back-pressure
    dec(1, 2, 3, 0, 22, 1); tick();
    iss_ready = 0;
    dec(1, 2, 3, 0, 23, 1);
    repeat (3) begin
      #1 check("bp_ready", dec_ready, 0);
      tick();
    end
    iss_ready = 1;
    #1 check("bp_issue", iss_valid, 1);
    tick();
    dec_valid = 0; tick();
    kill(0);
    kill(1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      flush = $urandom_range(0, 39) == 0;
      dec(4'($urandom_range(0, 9)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0);
      dec_valid = $urandom_range(0, 9) < 7;
      iss_ready = $urandom_range(0, 3) != 0;
      wb_valid = $urandom_range(0, 99) < 35;
      wb_rd = 5'($urandom_range(0, 7));
      divsqrt_done = $urandom_range(0, 4) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
